// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a word RAM between fetch and data ports, adding byte loads and RMW byte stores.
// Define MEM_ARB_RR_EN for round-robin contention instead of data priority with a starvation guard.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_ad,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [31:0] d_ad,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        busy,
  output logic [31:0] ram_ad,
  output logic [31:0] ram_d,
  output logic        ram_we,
  input  logic [31:0] ram_q
);
  typedef enum logic [1:0] {IDLE, RD, RMW} state_t;
  localparam logic [31:0] AMASK = 32'((64'd1 << ADDR_WIDTH) - 64'd1);
  state_t r_state, w_next;
  logic r_own_d, r_byte, r_if_rvalid, r_d_rvalid, r_d_done;
  logic [31:0] r_ad, r_if_rdata, r_d_rdata;
  logic [7:0] r_wdata;
  logic w_idle, w_pick_if, w_if_gnt, w_d_gnt;
`ifdef MEM_ARB_RR_EN
  logic r_last_d;
  assign w_pick_if = r_last_d;
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [SW-1:0] r_starve;
  assign w_pick_if = r_starve == SMAX;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    if (w_if_gnt || (w_d_gnt && !d_we)) w_next = RD;
    else if (w_d_gnt && d_byte) w_next = RMW;
  end
  // grants and RAM drive are combinational so the access starts in the accept cycle
  always_comb begin
    w_idle = r_state == IDLE;
    w_if_gnt = rst_n && w_idle && if_req && (!d_req || w_pick_if);
    w_d_gnt = rst_n && w_idle && d_req && !w_if_gnt;
    ram_ad = (r_state == RMW) ? r_ad : ((w_if_gnt ? if_ad : d_ad) & AMASK);
    ram_d = (r_state == RMW) ? {r_wdata, ram_q[23:0]} : d_wdata;
    ram_we = rst_n && ((w_d_gnt && d_we && !d_byte) || r_state == RMW);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own_d <= 1'b0;
      r_byte <= 1'b0;
      r_ad <= '0;
      r_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_d_done <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_d <= 1'b1;
`else
      r_starve <= '0;
`endif
    end else begin
      r_if_rvalid <= r_state == RD && !r_own_d;
      r_d_rvalid <= r_state == RD && r_own_d;
      r_d_done <= (w_d_gnt && d_we && !d_byte) || r_state == RMW;
      if (r_state == RD && !r_own_d) r_if_rdata <= ram_q;
      if (r_state == RD && r_own_d) r_d_rdata <= r_byte ? {24'h0, ram_q[31:24]} : ram_q;
      if (w_if_gnt || w_d_gnt) begin
        r_own_d <= w_d_gnt;
        r_byte <= w_d_gnt && d_byte;
        r_ad <= ram_ad;
        r_wdata <= d_wdata[7:0];
      end
`ifdef MEM_ARB_RR_EN
      if (w_if_gnt || w_d_gnt) r_last_d <= w_d_gnt;
`else
      if (w_idle) r_starve <= (!if_req || w_if_gnt) ? '0 : (r_starve != SMAX) ? r_starve + 1'b1 : r_starve;
`endif
    end
  end
  assign if_gnt = w_if_gnt;
  assign d_gnt = w_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata = r_if_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata = r_d_rdata;
  assign d_done = r_d_done;
  assign busy = r_state != IDLE;
endmodule
